apb_completer_regs: RTL and testbench

APB_COMPLETER_REGS -- requirements
Module: apb_completer_regs

---
 rtl/apb_completer_regs.sv | 158 +++++++++++++++
 tb/tb_apb_completer_regs.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_completer_regs.sv
// APB-style register completer: CTRL, WAIT, STATUS, ID and four scratch
// registers behind a three-state (IDLE/WAIT/DONE) handshake with a
// programmable number of wait states and an error response above 0x07.
module apb_completer_regs #(
  parameter logic [1:0] SLAVE_ID = 2'b01,
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sel,
  input  logic       enable,
  input  logic       write,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ready,
  output logic       slverr,
  output logic [7:0] ctrl_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t     state;
  logic [2:0] wait_cnt;
  logic [7:0] cap_addr;
  logic       cap_write;
  logic [7:0] cap_wdata;

  logic [7:0] ctrl;
  logic [2:0] wait_states;
  logic [7:0] status;
  logic [7:0] scratch [4];

  logic       selected;
  logic       setup;
  logic       addr_err;
  logic [7:0] rd_val;

  assign selected = (sel == SLAVE_ID);
  assign setup    = selected && !enable;
  assign addr_err = |cap_addr[7:3];
  assign ctrl_out = ctrl;

  // Read multiplexer for the captured address.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    rd_val = 8'h00;
    case (cap_addr)
      8'h00:                      rd_val = ctrl;
      8'h01:                      rd_val = {5'b00000, wait_states};
      8'h02:                      rd_val = status;
      8'h03:                      rd_val = ID_VALUE;
      8'h04, 8'h05, 8'h06, 8'h07: rd_val = scratch[cap_addr[1:0]];
      default:                    rd_val = 8'h00;
    endcase
  end

  // Handshake state machine, register file and registered response outputs.
  // NOTE: all state here is updated with non-blocking assignments so every
  // right-hand side sees the pre-edge value, matching flip-flop behaviour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      wait_cnt    <= 3'd0;
      cap_addr    <= 8'h00;
      cap_write   <= 1'b0;
      cap_wdata   <= 8'h00;
      ctrl        <= 8'h00;
      wait_states <= 3'd0;
      status      <= 8'h00;
      rdata       <= 8'h00;
      ready       <= 1'b0;
      slverr      <= 1'b0;
      // NOTE: the scratch array is architecturally visible after reset, so it
      // is cleared like any other register; it is small enough to be flops.
      for (int i = 0; i < 4; i++) begin
        scratch[i] <= 8'h00;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          ready  <= 1'b0;
          slverr <= 1'b0;
          // A lone enable without a preceding setup is simply ignored here.
          if (setup) begin
            state     <= ST_WAIT;
            cap_addr  <= addr;
            cap_write <= write;
            cap_wdata <= wdata;
            wait_cnt  <= wait_states;
          end
        end

        ST_WAIT: begin
          if (!selected) begin
            // Master walked away: abandon the transfer without side effects.
            state  <= ST_IDLE;
            ready  <= 1'b0;
            slverr <= 1'b0;
          end else if (enable) begin
            if (wait_cnt != 3'd0) begin
              wait_cnt <= wait_cnt - 3'd1;
            end else begin
              state  <= ST_DONE;
              ready  <= 1'b1;
              status <= status + 8'd1;
              if (addr_err) begin
                slverr <= 1'b1;
                rdata  <= 8'h00;
              end else begin
                slverr <= 1'b0;
                if (cap_write) begin
                  // STATUS and ID silently ignore writes.
                  case (cap_addr)
                    8'h00:                      ctrl        <= cap_wdata;
                    8'h01:                      wait_states <= cap_wdata[2:0];
                    8'h04, 8'h05, 8'h06, 8'h07: scratch[cap_addr[1:0]] <= cap_wdata;
                    default:                    ;
                  endcase
                end else begin
                  rdata <= rd_val;
                end
              end
            end
          end
          // Selected but enable still low: hold the counter and keep waiting.
        end

        ST_DONE: begin
          ready  <= 1'b0;
          slverr <= 1'b0;
          if (setup) begin
            // Back-to-back transfer: the next setup is already on the bus.
            state     <= ST_WAIT;
            cap_addr  <= addr;
            cap_write <= write;
            cap_wdata <= wdata;
            wait_cnt  <= wait_states;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state  <= ST_IDLE;
          ready  <= 1'b0;
          slverr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_completer_regs.sv
// Self-checking bench for apb_completer_regs: directed scenarios plus
// randomized transfers compared against a register-map model.
module tb_apb_completer_regs;

  localparam logic [1:0] ID  = 2'b01;
  localparam logic [7:0] IDV = 8'hA5;

  logic       clk;
  logic       reset;
  logic [1:0] sel;
  logic       enable;
  logic       write;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ready;
  logic       slverr;
  logic [7:0] ctrl_out;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the register map as plain variables.
  logic [7:0] m_ctrl;
  logic [7:0] m_wait;
  logic [7:0] m_status;
  logic [7:0] m_scratch [4];
  logic [7:0] m_rdata;

  apb_completer_regs #(.SLAVE_ID(ID), .ID_VALUE(IDV)) dut (
    .clk      (clk),
    .reset    (reset),
    .sel      (sel),
    .enable   (enable),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .slverr   (slverr),
    .ctrl_out (ctrl_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl   = 8'h00;
    m_wait   = 8'h00;
    m_status = 8'h00;
    m_rdata  = 8'h00;
    for (int i = 0; i < 4; i++) m_scratch[i] = 8'h00;
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    if (a == 8'h00) return m_ctrl;
    if (a == 8'h01) return m_wait;
    if (a == 8'h02) return m_status;
    if (a == 8'h03) return IDV;
    if (a < 8'h08)  return m_scratch[a - 8'h04];
    return 8'h00;
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'h00) m_ctrl = d;
    else if (a == 8'h01) m_wait = d & 8'h07;
    else if (a >= 8'h04 && a < 8'h08) m_scratch[a - 8'h04] = d;
  endtask

  // One complete transfer. Starts driving setup at the current time (just
  // after an edge) and returns just after the edge that raised ready, with
  // the bus still in its access phase.
  task automatic do_xfer(input logic [7:0] a, input logic wr, input logic [7:0] wd,
                         input int hold);
    int         w;
    logic [7:0] exp_rd;
    logic       exp_err;
    sel    = ID;
    enable = 1'b0;
    write  = wr;
    addr   = a;
    wdata  = wd;
    w      = int'(m_wait);
    @(posedge clk); #1;
    check("setup_ready", 32'(ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_ready", 32'(ready), 32'd0);
    end
    enable = 1'b1;
    for (int k = 1; k <= w + 1; k++) begin
      @(posedge clk); #1;
      if (k == w + 1) check("ready_high", 32'(ready), 32'd1);
      else            check("ready_early", 32'(ready), 32'd0);
    end
    exp_err = (a >= 8'h08);
    if (exp_err)  exp_rd = 8'h00;
    else if (!wr) exp_rd = model_read(a);
    else          exp_rd = m_rdata;
    if (!exp_err && wr) model_write(a, wd);
    m_status = m_status + 8'd1;
    m_rdata  = exp_rd;
    check("rdata", 32'(rdata), 32'(exp_rd));
    check("slverr", 32'(slverr), 32'(exp_err));
    check("ctrl_out", 32'(ctrl_out), 32'(m_ctrl));
  endtask

  // Release the bus after a transfer; optionally present a stray enable
  // without any setup, which must be ignored.
  task automatic bus_idle(input logic stray);
    sel    = 2'b00;
    enable = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", 32'(ready), 32'd0);
    check("idle_slverr", 32'(slverr), 32'd0);
    if (stray) begin
      sel    = ID;
      enable = 1'b1;
      @(posedge clk); #1;
      check("stray_ready", 32'(ready), 32'd0);
      sel    = 2'b10;
      enable = 1'b0;
      @(posedge clk); #1;
      check("stray_ready2", 32'(ready), 32'd0);
    end
  endtask

  task automatic random_xfers(input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = 8'($urandom_range(0, 15));
      do_xfer(a, 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 2));
      // Roughly half the transfers run back to back from DONE.
      if ($urandom_range(0, 1) == 0) bus_idle(1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset  = 1'b1;
    sel    = 2'b00;
    enable = 1'b0;
    write  = 1'b0;
    addr   = 8'h00;
    wdata  = 8'h00;
    model_reset();
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_slverr", 32'(slverr), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_ctrl_out", 32'(ctrl_out), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Scratch write/read with zero wait states, then STATUS readback.
    do_xfer(8'h04, 1'b1, 8'h5C, 0);
    bus_idle(1'b0);
    do_xfer(8'h04, 1'b0, 8'h00, 0);
    check("scratch_5c", 32'(rdata), 32'h5C);
    bus_idle(1'b0);
    do_xfer(8'h02, 1'b0, 8'h00, 0);
    check("status_2", 32'(rdata), 32'd2);
    bus_idle(1'b0);

    // Three wait states, then read the ID register.
    do_xfer(8'h01, 1'b1, 8'h03, 0);
    bus_idle(1'b0);
    do_xfer(8'h03, 1'b0, 8'h00, 1);
    check("id_value", 32'(rdata), 32'hA5);
    check("id_slverr", 32'(slverr), 32'd0);
    bus_idle(1'b0);

    // Out-of-range addresses.
    do_xfer(8'h09, 1'b0, 8'h00, 0);
    check("err_rd_slverr", 32'(slverr), 32'd1);
    bus_idle(1'b0);
    do_xfer(8'h0F, 1'b1, 8'h11, 0);
    check("err_wr_rdata", 32'(rdata), 32'd0);
    bus_idle(1'b0);
    do_xfer(8'h02, 1'b0, 8'h00, 0);
    check("status_after_err", 32'(rdata), 32'd7);
    bus_idle(1'b0);

    // Abort during a wait state: scratch 5 and STATUS must not move.
    do_xfer(8'h05, 1'b1, 8'h42, 0);
    bus_idle(1'b0);
    sel    = ID;
    enable = 1'b0;
    write  = 1'b1;
    addr   = 8'h05;
    wdata  = 8'h99;
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    check("abort_pre", 32'(ready), 32'd0);
    sel = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("abort_ready", 32'(ready), 32'd0);
    end
    enable = 1'b0;
    do_xfer(8'h05, 1'b0, 8'h00, 0);
    check("abort_scratch", 32'(rdata), 32'h42);
    bus_idle(1'b0);

    // Randomized traffic against the model.
    random_xfers(200);
    bus_idle(1'b0);

    // Asynchronous reset while ready is high with CTRL = 0xFF.
    do_xfer(8'h01, 1'b1, 8'h00, 0);
    bus_idle(1'b0);
    do_xfer(8'h00, 1'b1, 8'hFF, 0);
    bus_idle(1'b0);
    do_xfer(8'h00, 1'b0, 8'h00, 0);
    check("ctrl_ff", 32'(ctrl_out), 32'hFF);
    #2 reset = 1'b1;
    #1;
    check("async_ready", 32'(ready), 32'd0);
    check("async_ctrl_out", 32'(ctrl_out), 32'd0);
    check("async_rdata", 32'(rdata), 32'd0);
    check("async_slverr", 32'(slverr), 32'd0);
    model_reset();
    sel    = 2'b00;
    enable = 1'b0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(ready), 32'd0);

    // STATUS wrap: 255 transfers, then three STATUS reads (255, 0, 1).
    random_xfers(255);
    bus_idle(1'b0);
    do_xfer(8'h02, 1'b0, 8'h00, 0);
    check("status_255", 32'(rdata), 32'd255);
    bus_idle(1'b0);
    do_xfer(8'h02, 1'b0, 8'h00, 0);
    check("status_wrap0", 32'(rdata), 32'd0);
    bus_idle(1'b0);
    do_xfer(8'h02, 1'b0, 8'h00, 0);
    check("status_wrap1", 32'(rdata), 32'd1);
    bus_idle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
